traffic_light_fsm: RTL and testbench

- Consumer end of the interval-lookup interface. Drives the 2-bit interval request to the time-parameter store and counts down the 4-bit value returned.
- Sequences main-road and side-road lamps and a pedestrian walk lamp.
- Paced by a 1 Hz tick enable. Owns all lamp outputs at the top level of the controller.

---
 rtl/traffic_light_fsm_pkg.sv | 68 ++++++
 rtl/traffic_light_fsm_if.sv | 21 ++
 rtl/traffic_light_fsm_interval_countdown.sv | 67 ++++++
 rtl/traffic_light_fsm.sv | 91 +++++++++
 tb/tb_traffic_light_fsm.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the traffic light controller and the interval store it talks to.
// Holds selector codes, lamp encodings, phase codes and the phase-to-outputs mapping.
package traffic_light_fsm_pkg;

    localparam int VALUE_WIDTH = 4;

    typedef logic [1:0] intervalSel_t;
    localparam intervalSel_t SEL_BASE     = 2'b00;
    localparam intervalSel_t SEL_EXTENDED = 2'b01;
    localparam intervalSel_t SEL_YELLOW   = 2'b10;

    // Lamp bits are ordered {red, yellow, green}.
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

    typedef logic [2:0] phase_t;
    localparam phase_t PH_MAIN_G  = 3'd0;
    localparam phase_t PH_MAIN_GX = 3'd1;
    localparam phase_t PH_MAIN_Y  = 3'd2;
    localparam phase_t PH_WALK    = 3'd3;
    localparam phase_t PH_SIDE_G  = 3'd4;
    localparam phase_t PH_SIDE_GX = 3'd5;
    localparam phase_t PH_SIDE_Y  = 3'd6;

    typedef struct packed {
        intervalSel_t interval;
        lamp_t        mainLamp;
        lamp_t        sideLamp;
        logic         walk;
    } phaseOutputs_t;

    function automatic phaseOutputs_t phaseOutputs(input phase_t phase);
        phaseOutputs_t o;
        o.interval = SEL_BASE;
        o.mainLamp = LAMP_RED;
        o.sideLamp = LAMP_RED;
        o.walk     = 1'b0;
        case (phase)
            PH_MAIN_G: o.mainLamp = LAMP_GREEN;
            PH_MAIN_GX: begin
                o.interval = SEL_EXTENDED;
                o.mainLamp = LAMP_GREEN;
            end
            PH_MAIN_Y: begin
                o.interval = SEL_YELLOW;
                o.mainLamp = LAMP_YELLOW;
            end
            PH_WALK: begin
                o.interval = SEL_EXTENDED;
                o.walk     = 1'b1;
            end
            PH_SIDE_G: o.sideLamp = LAMP_GREEN;
            PH_SIDE_GX: begin
                o.interval = SEL_EXTENDED;
                o.sideLamp = LAMP_GREEN;
            end
            PH_SIDE_Y: begin
                o.interval = SEL_YELLOW;
                o.sideLamp = LAMP_YELLOW;
            end
            default: o.mainLamp = LAMP_GREEN;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Interval-lookup link between the controller (master) and the time-parameter store (slave).
interface traffic_light_fsm_if;
    import traffic_light_fsm_pkg::*;

    intervalSel_t           requested_interval;
    logic [VALUE_WIDTH-1:0] interval_value;
    logic                   param_busy;

    modport master (
        output requested_interval,
        input  interval_value,
        input  param_busy
    );

    modport slave (
        input  requested_interval,
        output interval_value,
        output param_busy
    );

endinterface

// File: rtl/traffic_light_fsm_interval_countdown.sv
// Per-phase timer: waits for the store to settle on the new request, loads its value,
// then counts 1 Hz ticks down and flags expiry on the tick that would reach zero.
module traffic_light_fsm_interval_countdown
    import traffic_light_fsm_pkg::*;
#(
    parameter int LOAD_LATENCY = 2,
    parameter int TICK_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   busy_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    input  logic                   tick_i,
    output logic                   expired_o,
    output logic                   running_o
);

    localparam int SETTLE_WIDTH = $clog2(LOAD_LATENCY + 1);

    logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
    logic [TICK_WIDTH-1:0]   count_q, count_d;
    logic                    running_q, running_d;
    logic [TICK_WIDTH-1:0]   loadValue;

    // A zero interval would never expire, so it is stretched to a single tick.
    assign loadValue = (value_i == '0) ? TICK_WIDTH'(1) : TICK_WIDTH'(value_i);

    assign expired_o = running_q && tick_i && (count_q == TICK_WIDTH'(1));
    assign running_o = running_q;

    always_comb begin
        settle_d  = settle_q;
        count_d   = count_q;
        running_d = running_q;
        if (start_i) begin
            settle_d  = SETTLE_WIDTH'(LOAD_LATENCY);
            count_d   = '0;
            running_d = 1'b0;
        end else if (!running_q) begin
            if (!busy_i) begin
                if (settle_q <= SETTLE_WIDTH'(1)) begin
                    settle_d  = '0;
                    count_d   = loadValue;
                    running_d = 1'b1;
                end else begin
                    settle_d = settle_q - SETTLE_WIDTH'(1);
                end
            end
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - TICK_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q  <= SETTLE_WIDTH'(LOAD_LATENCY);
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            settle_q  <= settle_d;
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic light controller: sequences main/side/walk phases, requests each phase's interval
// from the parameter store and owns all registered lamp outputs.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int LOAD_LATENCY = 2,
    parameter int TICK_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       global_reset,
    input  logic                       tick_1hz,
    input  logic                       side_sensor,
    input  logic                       walk_button,
    traffic_light_fsm_if.master        store,
    output logic [2:0]                 main_lights,
    output logic [2:0]                 side_lights,
    output logic                       walk_lamp,
    output logic                       phase_expired
);

    phase_t        phase_q, phase_d;
    phase_t        nextPhase;
    phaseOutputs_t outputs_q, outputs_d;
    logic          walkPending_q, walkPending_d;
    logic          phaseExpired_q;
    logic          expired;
    logic          running;

    traffic_light_fsm_interval_countdown #(
        .LOAD_LATENCY(LOAD_LATENCY),
        .TICK_WIDTH  (TICK_WIDTH)
    ) timer (
        .clk      (clk),
        .rst      (global_reset),
        .start_i  (expired),
        .busy_i   (store.param_busy),
        .value_i  (store.interval_value),
        .tick_i   (tick_1hz && running),
        .expired_o(expired),
        .running_o(running)
    );

    always_comb begin
        case (phase_q)
            PH_MAIN_G:  nextPhase = side_sensor ? PH_MAIN_Y : PH_MAIN_GX;
            PH_MAIN_GX: nextPhase = PH_MAIN_Y;
            PH_MAIN_Y:  nextPhase = walkPending_q ? PH_WALK : PH_SIDE_G;
            PH_WALK:    nextPhase = PH_SIDE_G;
            PH_SIDE_G:  nextPhase = side_sensor ? PH_SIDE_GX : PH_SIDE_Y;
            PH_SIDE_GX: nextPhase = PH_SIDE_Y;
            PH_SIDE_Y:  nextPhase = PH_MAIN_G;
            default:    nextPhase = PH_MAIN_G;
        endcase
    end

    // Lamps and the interval request follow the phase on the same edge; a press that
    // coincides with entering WALK is consumed by that WALK.
    always_comb begin
        phase_d       = phase_q;
        outputs_d     = outputs_q;
        walkPending_d = walkPending_q | walk_button;
        if (expired) begin
            phase_d   = nextPhase;
            outputs_d = phaseOutputs(nextPhase);
            if (nextPhase == PH_WALK) begin
                walkPending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            phase_q        <= PH_MAIN_G;
            outputs_q      <= phaseOutputs(PH_MAIN_G);
            walkPending_q  <= 1'b0;
            phaseExpired_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            outputs_q      <= outputs_d;
            walkPending_q  <= walkPending_d;
            phaseExpired_q <= expired;
        end
    end

    assign store.requested_interval = outputs_q.interval;
    assign main_lights              = outputs_q.mainLamp;
    assign side_lights              = outputs_q.sideLamp;
    assign walk_lamp                = outputs_q.walk;
    assign phase_expired            = phaseExpired_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: a phase-level reference model predicts every expiry
// and the outputs of the phase that follows; a monitor matches them against the DUT pulses.
module tb_traffic_light_fsm;

    localparam int LOAD_LATENCY = 2;
    localparam int MAX_WAIT     = 400;

    logic       clk          = 1'b0;
    logic       global_reset = 1'b1;
    logic       tick_1hz     = 1'b0;
    logic       side_sensor  = 1'b0;
    logic       walk_button  = 1'b0;
    logic       paramBusy    = 1'b0;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic       phase_expired;
    logic [3:0] storeValue   = 4'd0;
    logic [3:0] valueTable [4];

    int passCount  = 0;
    int checkCount = 0;
    int cycleCount = 0;

    typedef enum int {MAIN_G, MAIN_GX, MAIN_Y, WALK, SIDE_G, SIDE_GX, SIDE_Y} phaseName_t;

    typedef struct {
        int          cycle;
        phaseName_t  phase;
        logic [1:0]  interval;
        logic [2:0]  mainL;
        logic [2:0]  sideL;
        logic        walk;
    } expect_t;

    expect_t expQ [$];

    phaseName_t mPhase       = MAIN_G;
    bit         mLoading     = 1'b1;
    int         mLoadLeft    = LOAD_LATENCY;
    int         mTicksLeft   = 0;
    bit         mWalkPending = 1'b0;

    traffic_light_fsm_if storeIf ();
    assign storeIf.param_busy     = paramBusy;
    assign storeIf.interval_value = storeValue;

    traffic_light_fsm #(
        .LOAD_LATENCY(LOAD_LATENCY),
        .TICK_WIDTH  (4)
    ) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .tick_1hz     (tick_1hz),
        .side_sensor  (side_sensor),
        .walk_button  (walk_button),
        .store        (storeIf),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk_lamp    (walk_lamp),
        .phase_expired(phase_expired)
    );

    always #5 clk = ~clk;

    // Store model: one register stage, output frozen while it is being reprogrammed.
    always @(posedge clk) begin
        if (!paramBusy) begin
            storeValue <= valueTable[storeIf.requested_interval];
        end
    end

    function automatic logic [1:0] intervalFor(input phaseName_t p);
        case (p)
            MAIN_GX, WALK, SIDE_GX: return 2'b01;
            MAIN_Y, SIDE_Y:         return 2'b10;
            default:                return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] mainLampFor(input phaseName_t p);
        case (p)
            MAIN_G, MAIN_GX: return 3'b001;
            MAIN_Y:          return 3'b010;
            default:         return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] sideLampFor(input phaseName_t p);
        case (p)
            SIDE_G, SIDE_GX: return 3'b001;
            SIDE_Y:          return 3'b010;
            default:         return 3'b100;
        endcase
    endfunction

    function automatic phaseName_t successor(input phaseName_t p, input logic side, input bit pending);
        case (p)
            MAIN_G:  return side ? MAIN_Y : MAIN_GX;
            MAIN_GX: return MAIN_Y;
            MAIN_Y:  return pending ? WALK : SIDE_G;
            WALK:    return SIDE_G;
            SIDE_G:  return side ? SIDE_GX : SIDE_Y;
            SIDE_GX: return SIDE_Y;
            default: return MAIN_G;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        checkCount++;
        if (actual == required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cycleCount);
        end
    endtask

    // Reference model: a phase waits LOAD_LATENCY unstalled clocks, then lasts N ticks.
    always @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            mPhase       = MAIN_G;
            mLoading     = 1'b1;
            mLoadLeft    = LOAD_LATENCY;
            mTicksLeft   = 0;
            mWalkPending = 1'b0;
            expQ.delete();
        end else begin
            bit         expire;
            phaseName_t nxt;
            expect_t    e;
            int         stored;
            cycleCount++;
            expire = 1'b0;
            nxt    = mPhase;
            if (mLoading) begin
                if (!paramBusy) begin
                    mLoadLeft--;
                    if (mLoadLeft == 0) begin
                        stored     = int'(valueTable[intervalFor(mPhase)]);
                        mTicksLeft = (stored == 0) ? 1 : stored;
                        mLoading   = 1'b0;
                    end
                end
            end else if (tick_1hz) begin
                mTicksLeft--;
                if (mTicksLeft == 0) begin
                    expire = 1'b1;
                    nxt    = successor(mPhase, side_sensor, mWalkPending);
                end
            end
            if (walk_button) mWalkPending = 1'b1;
            if (expire) begin
                if (nxt == WALK) mWalkPending = 1'b0;
                e.cycle    = cycleCount;
                e.phase    = nxt;
                e.interval = intervalFor(nxt);
                e.mainL    = mainLampFor(nxt);
                e.sideL    = sideLampFor(nxt);
                e.walk     = (nxt == WALK);
                expQ.push_back(e);
                mPhase    = nxt;
                mLoading  = 1'b1;
                mLoadLeft = LOAD_LATENCY;
            end
        end
    end

    // Monitor: every expiry pulse must match the oldest prediction, and no prediction may go unmet.
    always @(negedge clk) begin
        if (!global_reset) begin
            expect_t e;
            if (phase_expired) begin
                checkOutput("expiryPredicted", int'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("expiryCycle", cycleCount, e.cycle);
                    checkOutput("mainLamps", int'(main_lights), int'(e.mainL));
                    checkOutput("sideLamps", int'(side_lights), int'(e.sideL));
                    checkOutput("walkLamp", int'(walk_lamp), int'(e.walk));
                    checkOutput("requestedInterval", int'(storeIf.requested_interval), int'(e.interval));
                end
            end else if (expQ.size() != 0 && expQ[0].cycle <= cycleCount) begin
                checkOutput("expiryPulse", int'(phase_expired), 1);
                void'(expQ.pop_front());
            end
            checkCount++;
            assert (main_lights == 3'b100 || side_lights == 3'b100) begin
                passCount++;
            end else begin
                $display("[TB] FAIL lampInvariant: main=%b side=%b, required at least one red", main_lights, side_lights);
            end
        end
    end

    task automatic applyStimulus(input logic t, input logic s, input logic w, input logic b, input int cycles);
        repeat (cycles) begin
            tick_1hz    = t;
            side_sensor = s;
            walk_button = w;
            paramBusy   = b;
            @(negedge clk);
        end
    endtask

    task automatic applyRandom(input int cycles);
        repeat (cycles) begin
            tick_1hz    = ($urandom_range(0, 2) == 0);
            side_sensor = $urandom_range(0, 1) != 0;
            walk_button = ($urandom_range(0, 24) == 0);
            paramBusy   = ($urandom_range(0, 6) == 0);
            @(negedge clk);
        end
    endtask

    // Called at a negedge; reset lands mid-cycle so its effect is seen before any clock edge.
    task automatic doReset(input logic [3:0] baseV, input logic [3:0] extV, input logic [3:0] yelV, input int holdCycles);
        #2;
        global_reset  = 1'b1;
        tick_1hz      = 1'b0;
        side_sensor   = 1'b0;
        walk_button   = 1'b0;
        paramBusy     = 1'b0;
        valueTable[0] = baseV;
        valueTable[1] = extV;
        valueTable[2] = yelV;
        valueTable[3] = 4'd0;
        #1;
        checkOutput("resetMain", int'(main_lights), 1);
        checkOutput("resetSide", int'(side_lights), 4);
        checkOutput("resetWalk", int'(walk_lamp), 0);
        checkOutput("resetInterval", int'(storeIf.requested_interval), 0);
        checkOutput("resetExpired", int'(phase_expired), 0);
        repeat (holdCycles) @(negedge clk);
        checkOutput("resetHeldExpired", int'(phase_expired), 0);
        #2 global_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitModel(input phaseName_t p, input bit loading, input int ticks, input string name);
        int n;
        n = 0;
        while (!(mPhase == p && mLoading == loading && (ticks < 0 || mTicksLeft == ticks)) && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(n < MAX_WAIT), 1);
    endtask

    initial begin
        valueTable[0] = 4'd6;
        valueTable[1] = 4'd3;
        valueTable[2] = 4'd2;
        valueTable[3] = 4'd0;
        @(negedge clk);

        $display("[TB] default sequence, side road idle");
        doReset(4'd6, 4'd3, 4'd2, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 40);

        $display("[TB] side road occupied");
        doReset(4'd6, 4'd3, 4'd2, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 40);

        $display("[TB] single walk press during MAIN_G");
        doReset(4'd6, 4'd3, 4'd2, 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 80);

        $display("[TB] store busy during SIDE_Y load");
        doReset(4'd6, 4'd3, 4'd2, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        waitModel(SIDE_Y, 1'b1, -1, "reachSideYLoad");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 20);

        $display("[TB] zero base interval");
        doReset(4'd0, 4'd3, 4'd2, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 30);

        $display("[TB] reset in the middle of SIDE_G");
        doReset(4'd6, 4'd3, 4'd2, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        waitModel(SIDE_G, 1'b0, 3, "reachSideGCount3");
        doReset(4'd6, 4'd3, 4'd2, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12);

        $display("[TB] randomised traffic");
        doReset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2);
        applyRandom(900);
        doReset(4'($urandom_range(1, 4)), 4'($urandom_range(0, 3)), 4'($urandom_range(1, 3)), 2);
        applyRandom(900);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
